uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to a single UART
// transmitter. A packet (bytes up to req_last) holds the grant through a lock,
// and a lock whose owner goes quiet for LOCK_TIMEOUT idle cycles is dropped.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tx_en,
    output logic [PAYLOAD_BITS-1:0]         tx_data,
    input  logic                            tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            locked,
    output logic                            lock_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic                    locked_q, locked_d;
    logic                    pulse_q, pulse_d;
    logic [CW-1:0]           idle_cnt_q, idle_cnt_d;

    logic [NUM_REQ-1:0]      elig;
    logic [IDW-1:0]          win;
    logic                    win_found;
    logic                    accept;
    logic                    expire;

    // Eligible set: everybody when unlocked, only the lock owner when locked
    always_comb begin
        elig = req_valid;
        if (locked_q)
            elig = req_valid & (NUM_REQ'(1) << grant_q);
    end

    // Round-robin scan starting just after the last granted requester; the
    // owner itself is the final position so a locked owner is always found
    always_comb begin
        int idx;
        idx       = 0;
        win       = grant_q;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(grant_q) + i) % NUM_REQ;
            if (!win_found && elig[IDW'(idx)]) begin
                win       = IDW'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign accept = resetn && (state_q == IDLE) && !tx_busy && win_found;

    // One-hot ready to the winner, only in the accept cycle
    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[win] = 1'b1;
    end

    // Transfer sequencing: accept, one strobe cycle, then track busy rise/fall
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ISSUE;
                    tx_data_d = req_data[int'(win)*PAYLOAD_BITS +: PAYLOAD_BITS];
                    grant_d   = win;
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Packet lock and its idle watchdog; an accept always beats expiry
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        expire     = 1'b0;
        if (accept || !locked_q) begin
            idle_cnt_d = '0;
        end else if (state_q == IDLE && !req_valid[grant_q]) begin
            if (idle_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                idle_cnt_d = '0;
                expire     = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
        if (accept)
            locked_d = !req_last[win];
        else if (expire)
            locked_d = 1'b0;
        else
            locked_d = locked_q;
        pulse_d = expire;
    end

    // State and datapath registers; reset leaves requester 0 first in line
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            grant_q    <= IDW'(NUM_REQ - 1);
            locked_q   <= 1'b0;
            pulse_q    <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            locked_q   <= locked_d;
            pulse_q    <= pulse_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign tx_en        = (state_q == ISSUE);
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_q;
    assign locked       = locked_q;
    assign lock_timeout = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, a simple transmitter
// that raises busy two cycles after each strobe, a per-cycle reference model,
// table-driven arbitration vectors, directed corner sequences and a random run.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int PB       = 8;
    localparam int LT       = 8;
    localparam int BUSY_LEN = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*PB-1:0] req_data;
    logic            tx_en, tx_busy, locked, lock_timeout;
    logic [PB-1:0]   tx_data;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked), .lock_timeout(lock_timeout)
    );

    typedef struct packed { logic [7:0] d; logic l; } byte_t;
    typedef struct { logic [3:0] mask; logic [31:0] data; int exp_id; logic [7:0] exp_byte; } vec_t;

    byte_t       rq[N][$];
    logic [N-1:0] gate = '1;
    int  compared = 0, mismatched = 0, cyc = 0, acc_cnt = 0;
    int  en_age = 1000;
    bit  busy_hold = 1'b0, rstn_drv = 1'b0;

    // reference model: last grant, lock, idle count, transfer in flight
    int         m_ptr, m_idle;
    bit         m_locked, m_inflight, m_seen, e_txen, e_pulse;
    logic [7:0] e_data;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = N - 1; m_idle = 0; m_locked = 0; m_inflight = 0; m_seen = 0;
        e_txen = 0; e_pulse = 0; e_data = '0;
    endtask

    task automatic check_cycle();
        logic [N-1:0] elig, exp_rdy;
        int  win;
        bit  can, inflight_now, n_txen, n_pulse;
        elig = m_locked ? (N'(1) << m_ptr) : '1;
        elig &= req_valid;
        win = -1;
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (win < 0 && elig[j]) win = j;
        end
        can     = resetn && !m_inflight && !tx_busy && (win >= 0);
        exp_rdy = can ? (N'(1) << win) : '0;
        cmp("req_ready", req_ready, exp_rdy);
        cmp("tx_en", tx_en, e_txen);
        cmp("tx_data", tx_data, e_data);
        cmp("grant_id", grant_id, m_ptr);
        cmp("locked", locked, m_locked);
        cmp("lock_timeout", lock_timeout, e_pulse);
        for (int k = 0; k < N; k++)
            if (req_valid[k] && req_ready[k] && rq[k].size() > 0) begin
                void'(rq[k].pop_front());
                acc_cnt++;
            end
        if (!resetn) begin
            m_reset();
        end else begin
            n_txen = 0; n_pulse = 0;
            inflight_now = m_inflight;
            if (can) begin
                m_ptr = win; e_data = req_data[win*PB +: PB]; m_locked = !req_last[win];
                m_idle = 0; m_inflight = 1; m_seen = 0; n_txen = 1;
            end else begin
                if (m_inflight && !e_txen) begin
                    if (!m_seen) begin
                        if (tx_busy) m_seen = 1;
                    end else if (!tx_busy) m_inflight = 0;
                end
                if (!m_locked) m_idle = 0;
                else if (!inflight_now && !req_valid[m_ptr]) begin
                    m_idle++;
                    if (m_idle == LT) begin m_locked = 0; m_idle = 0; n_pulse = 1; end
                end
            end
            e_txen = n_txen; e_pulse = n_pulse;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (tx_en === 1'b1) en_age = 0; else if (en_age < 1000) en_age++;
        tx_busy = busy_hold || (en_age >= 2 && en_age < 2 + BUSY_LEN);
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0 && gate[k]) begin
                req_valid[k] = 1'b1; req_data[k*PB +: PB] = rq[k][0].d; req_last[k] = rq[k][0].l;
            end else begin
                req_valid[k] = 1'b0; req_data[k*PB +: PB] = PB'($urandom); req_last[k] = 1'($urandom);
            end
        end
        resetn = rstn_drv;
        @(negedge clk);
        check_cycle();
        cyc++;
    endtask

    task automatic clear_q();
        for (int k = 0; k < N; k++) rq[k].delete();
    endtask

    task automatic do_reset();
        clear_q(); gate = '1; busy_hold = 0;
        rstn_drv = 0; step(); step(); rstn_drv = 1;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic wait_en(output bit ok, input int budget);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (tx_en === 1'b1) ok = 1;
        end
    endtask

    initial begin
        vec_t       tbl[8];
        bit         ok;
        int         got, n, a0, pulses, pulse_cyc, fall_cyc, rdy1_at_pulse;
        logic [7:0] d_after;
        bit         prev_busy, seen_en;
        int         ord[5];
        logic [7:0] dat[4];
        logic       lck[4];

        tbl[0] = '{4'b0101, 32'h0042_0041, 0, 8'h41};
        tbl[1] = '{4'b0101, 32'h0042_0041, 2, 8'h42};
        tbl[2] = '{4'b1111, 32'h5453_5251, 3, 8'h54};
        tbl[3] = '{4'b1111, 32'h5453_5251, 0, 8'h51};
        tbl[4] = '{4'b0010, 32'h0000_6100, 1, 8'h61};
        tbl[5] = '{4'b0011, 32'h0000_7271, 0, 8'h71};
        tbl[6] = '{4'b1000, 32'h8300_0000, 3, 8'h83};
        tbl[7] = '{4'b1001, 32'h9300_0091, 0, 8'h91};

        resetn = 0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 0;
        m_reset();
        repeat (2) @(posedge clk);
        do_reset();
        cmp("reset_grant", grant_id, 3);
        cmp("reset_txdata", tx_data, 0);

        // table-driven single-byte arbitration from reset
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N; k++)
                if (tbl[r].mask[k]) rq[k].push_back('{tbl[r].data[k*8 +: 8], 1'b1});
            wait_en(ok, 40);
            cmp("tbl_en_seen", ok, 1);
            cmp("tbl_grant", grant_id, tbl[r].exp_id);
            cmp("tbl_byte", tx_data, tbl[r].exp_byte);
            clear_q();
            n = 0;
            for (int i = 0; i < 8; i++) begin step(); if (tx_en === 1'b1) n++; end
            cmp("tbl_extra_en", n, 0);
        end

        // all four valid continuously: grant order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 2; j++) rq[k].push_back('{8'(8'hA0 + k*16 + j), 1'b1});
        a0 = acc_cnt; got = 0;
        for (int i = 0; i < 200 && got < 5; i++) begin
            step();
            if (tx_en === 1'b1) begin ord[got] = int'(grant_id); got++; end
        end
        cmp("rr_count", got, 5);
        cmp("rr_ord0", ord[0], 0); cmp("rr_ord1", ord[1], 1); cmp("rr_ord2", ord[2], 2);
        cmp("rr_ord3", ord[3], 3); cmp("rr_ord4", ord[4], 0);
        cmp("rr_acc_vs_en", acc_cnt - a0, 5);

        // locked three-byte packet from req0 while req1 waits
        do_reset();
        rq[0].push_back('{8'hC0, 1'b0}); rq[0].push_back('{8'hC1, 1'b0}); rq[0].push_back('{8'hC2, 1'b1});
        rq[1].push_back('{8'hB0, 1'b1});
        got = 0;
        for (int i = 0; i < 200 && got < 4; i++) begin
            step();
            if (tx_en === 1'b1) begin dat[got] = tx_data; lck[got] = locked; got++; end
        end
        cmp("pkt_count", got, 4);
        cmp("pkt_d0", dat[0], 8'hC0); cmp("pkt_d1", dat[1], 8'hC1);
        cmp("pkt_d2", dat[2], 8'hC2); cmp("pkt_d3", dat[3], 8'hB0);
        cmp("pkt_l0", lck[0], 1); cmp("pkt_l1", lck[1], 1);
        cmp("pkt_l2", lck[2], 0); cmp("pkt_l3", lck[3], 0);

        // lock timeout: owner goes quiet, req1 waits
        do_reset();
        rq[0].push_back('{8'hD0, 1'b0});
        rq[1].push_back('{8'hE0, 1'b1});
        pulses = 0; pulse_cyc = -1; fall_cyc = -1; rdy1_at_pulse = 0; d_after = '0;
        prev_busy = 0; seen_en = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx_en === 1'b1 && !seen_en) seen_en = 1;
            else if (tx_en === 1'b1 && pulses > 0 && d_after == 8'h00) d_after = tx_data;
            if (seen_en && fall_cyc < 0 && prev_busy && !tx_busy) fall_cyc = cyc;
            if (lock_timeout === 1'b1) begin
                pulses++; pulse_cyc = cyc; rdy1_at_pulse = int'(req_ready[1]);
            end
            prev_busy = tx_busy;
        end
        cmp("to_pulses", pulses, 1);
        cmp("to_delay", pulse_cyc - fall_cyc, 9);
        cmp("to_req1_ready", rdy1_at_pulse, 1);
        cmp("to_req1_byte", d_after, 8'hE0);

        // busy held in IDLE blocks everything
        do_reset();
        busy_hold = 1;
        rq[0].push_back('{8'h11, 1'b1}); rq[1].push_back('{8'h22, 1'b1});
        n = 0; got = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_en === 1'b1) n++;
            if (req_ready !== '0) got++;
        end
        cmp("busy_no_en", n, 0);
        cmp("busy_no_ready", got, 0);
        busy_hold = 0;
        wait_en(ok, 10);
        cmp("busy_release_en", ok, 1);
        cmp("busy_release_grant", grant_id, 0);

        // reset during WAIT_DONE
        do_reset();
        rq[1].push_back('{8'h5A, 1'b1});
        wait_en(ok, 20);
        cmp("rst_first_en", ok, 1);
        for (int i = 0; i < 10 && tx_busy !== 1'b1; i++) step();
        step();
        rstn_drv = 0; step(); rstn_drv = 1;
        step();
        cmp("rst_tx_en", tx_en, 0); cmp("rst_tx_data", tx_data, 0);
        cmp("rst_grant", grant_id, 3); cmp("rst_locked", locked, 0);
        cmp("rst_pulse", lock_timeout, 0);
        rq[0].push_back('{8'h60, 1'b1}); rq[1].push_back('{8'h61, 1'b1});
        rq[2].push_back('{8'h62, 1'b1});
        wait_en(ok, 20);
        cmp("rst_next_en", ok, 1);
        cmp("rst_next_grant", grant_id, 0);
        cmp("rst_next_byte", tx_data, 8'h60);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(7) == 0 && rq[k].size() < 4)
                    rq[k].push_back('{8'($urandom), 1'($urandom_range(2) == 0)});
                gate[k] = ($urandom_range(7) != 0);
            end
            if ($urandom_range(63) == 0) busy_hold = !busy_hold;
            rstn_drv = ($urandom_range(499) != 0);
            step();
        end
        rstn_drv = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
